// File: rtl/lw_bus_arbiter.sv
// ---------------------------------------------------------------------------
// lw_bus_arbiter
//
// Two-master to one-slave Avalon-MM arbiter for the lightweight HPS-to-FPGA
// register window. Master 0 is the HPS lightweight bridge and master 1 is the
// FPGA-side sequencing engine. Both share one peripheral register port.
//
// Grants are round-robin. A granted transfer is held until the slave drops
// s_waitrequest. When the other master is waiting at completion, the grant
// passes directly to it with no idle bubble. Commands are not registered:
// the slave port is a combinational mux of the granted master's command.
//
// Optional feature, selected by the macro ARB_LOCK_EN:
//   When defined, a master that completes a transfer while asserting its lock
//   input and still requesting keeps the grant. This lets read-modify-write
//   sequences run back-to-back with no bubble. When undefined, m0_lock and
//   m1_lock are ignored and arbitration is pure round-robin.
//
// Parameters:
//   ADDR_W  word address width shared by masters and slave
//   DATA_W  data width; byteenable width is DATA_W/8
//
// Ports:
//   clk, reset                  system clock; synchronous active-high reset
//   m0_* / m1_*                 master-side Avalon-MM command inputs
//                               (address, read, write, writedata, byteenable,
//                               lock), plus readdata/waitrequest outputs
//   s_address, s_read, s_write,
//   s_writedata, s_byteenable   slave command outputs
//   s_readdata, s_waitrequest   slave response inputs
// ---------------------------------------------------------------------------
module lw_bus_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,

    // Master 0: HPS lightweight bridge
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_lock,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_waitrequest,

    // Master 1: FPGA sequencing engine
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_lock,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_waitrequest,

    // Shared slave port
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_waitrequest
);

    typedef enum logic [1:0] {
        StIdle,
        StGnt0,
        StGnt1
    } state_e;

    state_e state_q, state_d;
    // Most recently granted master; reset to 1 so master 0 wins the first tie.
    logic   last_q, last_d;

    logic m0_req;
    logic m1_req;
    logic m0_hold;
    logic m1_hold;
    logic xfer_done;

    assign m0_req    = m0_read | m0_write;
    assign m1_req    = m1_read | m1_write;
    assign xfer_done = ~s_waitrequest;

`ifdef ARB_LOCK_EN
    // Keep the grant past completion only while the owner is still requesting.
    assign m0_hold = m0_lock & m0_req;
    assign m1_hold = m1_lock & m1_req;
`else
    logic unused_lock;
    assign unused_lock = m0_lock ^ m1_lock;
    assign m0_hold     = 1'b0;
    assign m1_hold     = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;

        case (state_q)
            StIdle: begin
                if (m0_req && m1_req) begin
                    // Tie: grant the master that was not served last.
                    state_d = last_q ? StGnt0 : StGnt1;
                end else if (m0_req) begin
                    state_d = StGnt0;
                end else if (m1_req) begin
                    state_d = StGnt1;
                end
            end

            StGnt0: begin
                if (xfer_done) begin
                    if (m0_hold) begin
                        state_d = StGnt0;
                    end else if (m1_req) begin
                        state_d = StGnt1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            StGnt1: begin
                if (xfer_done) begin
                    if (m1_hold) begin
                        state_d = StGnt1;
                    end else if (m0_req) begin
                        state_d = StGnt0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // Every entry into (or stay in) a grant state records its owner; a locked
    // stay rewrites the same value, so `last` is effectively unchanged.
    always_comb begin
        last_d = last_q;
        if (state_d == StGnt0) begin
            last_d = 1'b0;
        end else if (state_d == StGnt1) begin
            last_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Output logic: slave command mux and per-master waitrequest
    // -----------------------------------------------------------------------
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;

        case (state_q)
            StGnt0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
            end

            StGnt1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
            end

            default: begin
            end
        endcase
    end

    // Read data is broadcast; each master qualifies it with its own waitrequest.
    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

endmodule

// File: tb/tb_lw_bus_arbiter.sv
module tb_lw_bus_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int BW = DW / 8;
`ifdef ARB_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;

    // Master command state, one entry per master
    logic          rd [2];
    logic          wr [2];
    logic          lk [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    logic [BW-1:0] be [2];
    int            remaining [2];
    bit            rnd_mode = 1'b0;

    logic [DW-1:0] s_readdata = '0;
    logic          s_waitrequest = 1'b0;

    logic [DW-1:0] m0_readdata, m1_readdata, s_writedata;
    logic          m0_waitrequest, m1_waitrequest, s_read, s_write;
    logic [AW-1:0] s_address;
    logic [BW-1:0] s_byteenable;

    lw_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0_address     (ad[0]),
        .m0_read        (rd[0]),
        .m0_write       (wr[0]),
        .m0_writedata   (wd[0]),
        .m0_byteenable  (be[0]),
        .m0_lock        (lk[0]),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
        .m1_address     (ad[1]),
        .m1_read        (rd[1]),
        .m1_write       (wr[1]),
        .m1_writedata   (wd[1]),
        .m1_byteenable  (be[1]),
        .m1_lock        (lk[1]),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
        .s_address      (s_address),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_writedata    (s_writedata),
        .s_byteenable   (s_byteenable),
        .s_readdata     (s_readdata),
        .s_waitrequest  (s_waitrequest)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the slave (-1 = nobody) and who was served last
    int owner = -1;
    int last  = 1;
    int cyc   = 0;
    int grant_log [$];
    int cyc_log [$];

    // Values sampled in the most recent cycle
    logic          smp_s_read, smp_s_write, smp_w0, smp_w1;
    logic [AW-1:0] smp_addr;
    logic [DW-1:0] smp_wdata, smp_rdata0, smp_rdata1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit req(input int x);
        return rd[x] | wr[x];
    endfunction

    task automatic new_cmd(input int x);
        bit is_rd;
        is_rd = ($urandom_range(0, 1) == 1);
        rd[x] = is_rd;
        wr[x] = ~is_rd;
        ad[x] = AW'($urandom);
        wd[x] = $urandom;
        be[x] = BW'($urandom);
        lk[x] = ($urandom_range(0, 1) == 1);
    endtask

    task automatic clear_cmd(input int x);
        rd[x] = 1'b0;
        wr[x] = 1'b0;
        lk[x] = 1'b0;
        remaining[x] = 0;
    endtask

    // One clock cycle: check outputs against the model at the falling edge,
    // advance the model across the rising edge, then update stimulus.
    task automatic cycle();
        logic          e_rd, e_wr, e_w0, e_w1;
        logic [AW-1:0] e_ad;
        logic [DW-1:0] e_wd;
        logic [BW-1:0] e_be;
        int            nxt, nlast;
        bit            done [2];

        @(negedge clk);
        smp_s_read = s_read;
        smp_s_write = s_write;
        smp_w0 = m0_waitrequest;
        smp_w1 = m1_waitrequest;
        smp_addr = s_address;
        smp_wdata = s_writedata;
        smp_rdata0 = m0_readdata;
        smp_rdata1 = m1_readdata;

        if (owner >= 0) begin
            e_rd = rd[owner]; e_wr = wr[owner]; e_ad = ad[owner];
            e_wd = wd[owner]; e_be = be[owner];
        end else begin
            e_rd = 1'b0; e_wr = 1'b0; e_ad = '0; e_wd = '0; e_be = '0;
        end
        e_w0 = (owner == 0) ? s_waitrequest : 1'b1;
        e_w1 = (owner == 1) ? s_waitrequest : 1'b1;

        check("s_read", 64'(s_read), 64'(e_rd));
        check("s_write", 64'(s_write), 64'(e_wr));
        check("s_address", 64'(s_address), 64'(e_ad));
        check("s_writedata", 64'(s_writedata), 64'(e_wd));
        check("s_byteenable", 64'(s_byteenable), 64'(e_be));
        check("m0_waitrequest", 64'(m0_waitrequest), 64'(e_w0));
        check("m1_waitrequest", 64'(m1_waitrequest), 64'(e_w1));
        check("m0_readdata", 64'(m0_readdata), 64'(s_readdata));
        check("m1_readdata", 64'(m1_readdata), 64'(s_readdata));

        // Model of the arbitration rules
        nxt = owner;
        nlast = last;
        if (reset) begin
            nxt = -1;
            nlast = 1;
        end else if (owner < 0) begin
            if (req(0) && req(1)) nxt = 1 - last;
            else if (req(0)) nxt = 0;
            else if (req(1)) nxt = 1;
        end else if (!s_waitrequest) begin
            grant_log.push_back(owner);
            cyc_log.push_back(cyc);
            if (LockEn && lk[owner] && req(owner)) nxt = owner;
            else if (req(1 - owner)) nxt = 1 - owner;
            else nxt = -1;
        end
        if (!reset && nxt >= 0) nlast = nxt;

        for (int x = 0; x < 2; x++) done[x] = (owner == x) && !s_waitrequest && req(x);

        @(posedge clk);
        #1;
        owner = nxt;
        last = nlast;
        cyc++;

        for (int x = 0; x < 2; x++) begin
            if (rnd_mode) begin
                if (done[x]) clear_cmd(x);
                if (!req(x) && $urandom_range(0, 2) != 0) new_cmd(x);
            end else if (done[x]) begin
                if (remaining[x] > 1) begin
                    remaining[x]--;
                    if (remaining[x] == 1) lk[x] = 1'b0;
                end else begin
                    clear_cmd(x);
                end
            end
        end
        if (rnd_mode) begin
            s_waitrequest = ($urandom_range(0, 2) == 0);
            s_readdata = $urandom;
            reset = ($urandom_range(0, 199) == 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        s_waitrequest = 1'b0;
        for (int x = 0; x < 2; x++) begin
            clear_cmd(x);
            ad[x] = '0; wd[x] = '0; be[x] = '0;
        end
        cycle();
        reset = 1'b0;
    endtask

    int base;
    int n0, n1;
    int exp_own [4];
    int exp_cyc [4];

    initial begin
        for (int x = 0; x < 2; x++) begin
            clear_cmd(x);
            ad[x] = '0; wd[x] = '0; be[x] = '0;
        end

        // Reset state
        do_reset();
        cycle();
        check("reset s_read", 64'(smp_s_read), 64'd0);
        check("reset s_write", 64'(smp_s_write), 64'd0);
        check("reset m0_wait", 64'(smp_w0), 64'd1);
        check("reset m1_wait", 64'(smp_w1), 64'd1);

        // Single master write, zero wait states
        wr[0] = 1'b1; ad[0] = 16'h0004; wd[0] = 32'hDEADBEEF; be[0] = 4'hF;
        remaining[0] = 1;
        cycle();
        check("t1 c1 s_write", 64'(smp_s_write), 64'd0);
        check("t1 c1 m0_wait", 64'(smp_w0), 64'd1);
        cycle();
        check("t1 c2 s_write", 64'(smp_s_write), 64'd1);
        check("t1 c2 wdata", 64'(smp_wdata), 64'hDEADBEEF);
        check("t1 c2 addr", 64'(smp_addr), 64'h4);
        check("t1 c2 m0_wait", 64'(smp_w0), 64'd0);
        cycle();
        check("t1 c3 s_write", 64'(smp_s_write), 64'd0);
        check("t1 c3 m0_wait", 64'(smp_w0), 64'd1);

        // Simultaneous first requests after reset
        do_reset();
        rd[0] = 1'b1; ad[0] = 16'h0010; remaining[0] = 1;
        rd[1] = 1'b1; ad[1] = 16'h0020; remaining[1] = 1;
        cycle();
        s_readdata = 32'h11;
        cycle();
        check("t2 m0 wait", 64'(smp_w0), 64'd0);
        check("t2 m0 rdata", 64'(smp_rdata0), 64'h11);
        check("t2 m0 addr", 64'(smp_addr), 64'h10);
        check("t2 m1 blocked", 64'(smp_w1), 64'd1);
        s_readdata = 32'h22;
        cycle();
        check("t2 m1 wait", 64'(smp_w1), 64'd0);
        check("t2 m1 rdata", 64'(smp_rdata1), 64'h22);
        check("t2 m1 addr", 64'(smp_addr), 64'h20);
        check("t2 m0 done", 64'(smp_w0), 64'd1);
        cycle();
        check("t2 idle s_read", 64'(smp_s_read), 64'd0);

        // Slave stall on an m1 read, m0 waiting meanwhile
        do_reset();
        rd[1] = 1'b1; ad[1] = 16'h0030; remaining[1] = 1;
        s_waitrequest = 1'b1;
        cycle();
        check("t3 c0 m1_wait", 64'(smp_w1), 64'd1);
        rd[0] = 1'b1; ad[0] = 16'h0040; remaining[0] = 1;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            check("t3 stall m1_wait", 64'(smp_w1), 64'd1);
            check("t3 stall m0_wait", 64'(smp_w0), 64'd1);
            check("t3 stall addr", 64'(smp_addr), 64'h30);
        end
        s_waitrequest = 1'b0;
        cycle();
        check("t3 c4 m1_wait", 64'(smp_w1), 64'd0);
        check("t3 c4 m0_wait", 64'(smp_w0), 64'd1);
        cycle();
        check("t3 c5 m0_wait", 64'(smp_w0), 64'd0);
        check("t3 c5 addr", 64'(smp_addr), 64'h40);
        check("t3 c5 m1_wait", 64'(smp_w1), 64'd1);

        // Fairness under continuous contention
        do_reset();
        rd[0] = 1'b1; ad[0] = 16'h0100; remaining[0] = 10;
        wr[1] = 1'b1; ad[1] = 16'h0200; remaining[1] = 10;
        grant_log.delete();
        cyc_log.delete();
        for (int i = 0; i < 30; i++) cycle();
        check("t4 transfers", 64'(grant_log.size()), 64'd20);
        n0 = 0;
        n1 = 0;
        foreach (grant_log[i]) begin
            check("t4 alternate", 64'(grant_log[i]), 64'(i % 2));
            if (grant_log[i] == 0) n0++;
            else n1++;
        end
        check("t4 m0 count", 64'(n0), 64'd10);
        check("t4 m1 count", 64'(n1), 64'd10);

        // Lock over three m0 writes while m1 waits
        do_reset();
        wr[0] = 1'b1; ad[0] = 16'h0300; lk[0] = 1'b1; remaining[0] = 3;
        wr[1] = 1'b1; ad[1] = 16'h0400; remaining[1] = 1;
        grant_log.delete();
        cyc_log.delete();
        base = cyc;
        for (int i = 0; i < 8; i++) cycle();
        if (LockEn) begin
            exp_own = '{0, 0, 0, 1};
            exp_cyc = '{1, 2, 3, 4};
        end else begin
            exp_own = '{0, 1, 0, 0};
            exp_cyc = '{1, 2, 3, 5};
        end
        check("t5 transfers", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check("t5 owner", 64'(grant_log[i]), 64'(exp_own[i]));
            check("t5 cycle", 64'(cyc_log[i] - base), 64'(exp_cyc[i]));
        end

        // Reset during a stalled m0 read
        do_reset();
        rd[0] = 1'b1; ad[0] = 16'h0050; remaining[0] = 1;
        s_waitrequest = 1'b1;
        cycle();
        cycle();
        check("t6 stalled s_read", 64'(smp_s_read), 64'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        rd[1] = 1'b1; ad[1] = 16'h0060; remaining[1] = 1;
        s_waitrequest = 1'b0;
        cycle();
        check("t6 post s_read", 64'(smp_s_read), 64'd0);
        check("t6 post m0_wait", 64'(smp_w0), 64'd1);
        check("t6 post m1_wait", 64'(smp_w1), 64'd1);
        cycle();
        check("t6 tie m0_wait", 64'(smp_w0), 64'd0);
        check("t6 tie addr", 64'(smp_addr), 64'h50);
        check("t6 tie m1_wait", 64'(smp_w1), 64'd1);

        // Randomized traffic against the reference model
        do_reset();
        rnd_mode = 1'b1;
        for (int i = 0; i < 3000; i++) cycle();
        rnd_mode = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
